// File: rtl/alu_pair_sequencer.sv
// Two-pass 16-bit register-pair sequencer (DAD/INX/DCX) in front of the 8-bit i8080 ALU.
// The low byte goes through first; its carry feeds the high-byte pass through the ALU FC input.

`ifndef FC
`define FC 0
`endif
`ifndef FP
`define FP 2
`endif
`ifndef FA
`define FA 4
`endif
`ifndef FZ
`define FZ 6
`endif
`ifndef FS
`define FS 7
`endif

module alu_pair_sequencer #(
    parameter int unsigned XLEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [2*XLEN-1:0] pair_a,
    input  logic [2*XLEN-1:0] pair_b,
    input  logic [XLEN-1:0]   flags_in,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] result,
    output logic [XLEN-1:0]   flags_out,
    output logic [XLEN-1:0]   alu_op_a,
    output logic [XLEN-1:0]   alu_op_b,
    output logic [4:0]        alu_control,
    output logic [XLEN-1:0]   alu_flags_in,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   alu_flags_out
);

    localparam int unsigned PW = 2 * XLEN;

    localparam logic [1:0] OpDad = 2'b00;
    localparam logic [1:0] OpInx = 2'b01;
    localparam logic [1:0] OpRsv = 2'b11;

    // Add with carry-in 0 (only FC written) / add with carry-in from FC.
    localparam logic [4:0] CtlAddLo = 5'b11_100;
    localparam logic [4:0] CtlAddHi = 5'b11_001;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [PW-1:0]   pair_a_q;
    logic [PW-1:0]   addend_q;
    logic [XLEN-1:0] flags_q;
    logic            carry_q;

    logic [PW-1:0]   start_addend;
    logic [XLEN-1:0] hi_flags;

    always_comb begin
        unique case (op)
            OpDad:   start_addend = pair_b;
            OpInx:   start_addend = {{(PW-1){1'b0}}, 1'b1};
            default: start_addend = '1;
        endcase
    end

    always_comb begin
        hi_flags        = flags_q;
        hi_flags[`FC]   = carry_q;
    end

    // ALU drive follows the state directly so the ALU sees operands for the whole byte pass.
    always_comb begin
        alu_op_a     = '0;
        alu_op_b     = '0;
        alu_control  = CtlAddLo;
        alu_flags_in = '0;
        unique case (state_q)
            StLo: begin
                alu_op_a     = pair_a_q[XLEN-1:0];
                alu_op_b     = addend_q[XLEN-1:0];
                alu_control  = CtlAddLo;
                alu_flags_in = flags_q;
            end
            StHi: begin
                alu_op_a     = pair_a_q[PW-1:XLEN];
                alu_op_b     = addend_q[PW-1:XLEN];
                alu_control  = CtlAddHi;
                alu_flags_in = hi_flags;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OpDad;
            pair_a_q  <= '0;
            addend_q  <= '0;
            flags_q   <= '0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags_out <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && op != OpRsv) begin
                        op_q     <= op;
                        pair_a_q <= pair_a;
                        addend_q <= start_addend;
                        flags_q  <= flags_in;
                        busy     <= 1'b1;
                        state_q  <= StLo;
                    end
                end
                StLo: begin
                    result[XLEN-1:0] <= alu_out;
                    carry_q          <= alu_flags_out[`FC];
                    state_q          <= StHi;
                end
                StHi: begin
                    result[PW-1:XLEN] <= alu_out;
                    // INX/DCX leave every flag alone; DAD takes the ALU's FC update.
                    flags_out         <= (op_q == OpDad) ? alu_flags_out : flags_q;
                    busy              <= 1'b0;
                    done              <= 1'b1;
                    state_q           <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pair_sequencer.sv
// Directed bench for alu_pair_sequencer with a behavioural 8-bit ALU (add / add-with-carry, FC only).

`ifndef FC
`define FC 0
`endif
`ifndef FZ
`define FZ 6
`endif
`ifndef FS
`define FS 7
`endif

module tb_alu_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] pair_a;
    logic [15:0] pair_b;
    logic [7:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  flags_out;
    logic [7:0]  alu_op_a;
    logic [7:0]  alu_op_b;
    logic [4:0]  alu_control;
    logic [7:0]  alu_flags_in;
    logic [7:0]  alu_out;
    logic [7:0]  alu_flags_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pair_sequencer #(.XLEN(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .pair_a       (pair_a),
        .pair_b       (pair_b),
        .flags_in     (flags_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .flags_out    (flags_out),
        .alu_op_a     (alu_op_a),
        .alu_op_b     (alu_op_b),
        .alu_control  (alu_control),
        .alu_flags_in (alu_flags_in),
        .alu_out      (alu_out),
        .alu_flags_out(alu_flags_out)
    );

    always #5 clk = ~clk;

    // ALU stand-in: control 11_001 adds FC as carry-in, 11_100 adds with carry-in 0; only FC written.
    logic       alu_cin;
    logic [8:0] alu_sum;
    always_comb begin
        alu_cin       = (alu_control[2:0] == 3'b001) ? alu_flags_in[`FC] : 1'b0;
        alu_sum       = {1'b0, alu_op_a} + {1'b0, alu_op_b} + {8'b0, alu_cin};
        alu_out       = alu_sum[7:0];
        alu_flags_out = alu_flags_in;
        alu_flags_out[`FC] = alu_sum[8];
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] pa;
        logic [15:0] pb;
        logic [7:0]  fin;
        logic [15:0] exp_result;
        logic [7:0]  exp_flags;
        logic        hi_cin;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit got;
        int lat;
        got = 0;
        lat = 0;
        @(negedge clk);
        op = v.op; pair_a = v.pa; pair_b = v.pb; flags_in = v.fin; start = 1'b1;
        @(posedge clk); #1;
        check({tag, " busy_lo"}, 32'(busy), 32'd1);
        check({tag, " ctl_lo"}, 32'(alu_control), 32'(5'b11_100));
        check({tag, " opa_lo"}, 32'(alu_op_a), 32'(v.pa[7:0]));
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check({tag, " ctl_hi"}, 32'(alu_control), 32'(5'b11_001));
                check({tag, " hi_cin"}, 32'(alu_flags_in[`FC]), 32'(v.hi_cin));
            end
            if (done) begin
                got = 1;
                lat = k;
                break;
            end
        end
        if (!got) begin
            check({tag, " done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " latency"}, 32'(lat), 32'd2);
            check({tag, " busy_done"}, 32'(busy), 32'd0);
            check({tag, " result"}, 32'(result), 32'(v.exp_result));
            check({tag, " flags"}, 32'(flags_out), 32'(v.exp_flags));
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        logic [15:0] seen_result;

        //               op     pa        pb        fin    result    flags  hi_cin
        vecs[0] = '{2'b00, 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h00, 1'b0};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 8'hC0, 16'h0000, 8'hC1, 1'b1};
        vecs[2] = '{2'b00, 16'h00FF, 16'h0001, 8'h00, 16'h0100, 8'h00, 1'b1};
        vecs[3] = '{2'b01, 16'hFFFF, 16'h5555, 8'h00, 16'h0000, 8'h00, 1'b1};
        vecs[4] = '{2'b10, 16'h0000, 16'h5555, 8'h01, 16'hFFFF, 8'h01, 1'b0};
        vecs[5] = '{2'b00, 16'h8000, 16'h8000, 8'h01, 16'h0000, 8'h01, 1'b0};
        vecs[6] = '{2'b01, 16'h12FF, 16'h0000, 8'hD5, 16'h1300, 8'hD5, 1'b1};
        vecs[7] = '{2'b10, 16'h1200, 16'h0000, 8'h00, 16'h11FF, 8'h00, 1'b0};
        vecs[8] = '{2'b00, 16'hABCD, 16'h1234, 8'h00, 16'hBE01, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; op = 2'b00;
        pair_a = '0; pair_b = '0; flags_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'(flags_out), 32'd0);
        check("rst op_a", 32'(alu_op_a), 32'd0);
        check("rst op_b", 32'(alu_op_b), 32'd0);
        check("rst alu_flags_in", 32'(alu_flags_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start held through LO, HI and DONE with other operands: must not disturb the op.
        ndone = 0;
        seen_result = '0;
        @(negedge clk);
        op = 2'b00; pair_a = 16'h1234; pair_b = 16'h1111; flags_in = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pair_a = 16'hFFFF; pair_b = 16'hFFFF; flags_in = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                seen_result = result;
            end
            @(negedge clk);
            if (ndone > 0) start = 1'b0;
        end
        check("held_start done_count", 32'(ndone), 32'd1);
        check("held_start result", 32'(seen_result), 32'h2345);
        check("held_start flags", 32'(flags_out), 32'd0);

        // Reserved op is dropped in IDLE.
        op = 2'b11; pair_a = 16'h0F0F; pair_b = 16'h0101; start = 1'b1;
        @(posedge clk); #1;
        check("rsv busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("rsv no_activity", 32'(ndone), 32'd0);
        check("rsv result_held", 32'(result), 32'h2345);

        // Reset during HI clears everything; a fresh op afterwards runs normally.
        @(negedge clk);
        op = 2'b00; pair_a = 16'h1234; pair_b = 16'h1111; flags_in = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst in_hi busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        check("midrst flags", 32'(flags_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst no_done", 32'(ndone), 32'd0);
        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
